// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline interlock/flush controller.
package pipe_ctrl_pkg;

   // Register-address width used by the ID-stage operand and destination fields.
   localparam int unsigned ADDR_W = 5;

   typedef enum logic [1:0] {
      StRun   = 2'd0,
      StStall = 2'd1,
      StFlush = 2'd2
   } state_e;

   // One in-flight destination register.
   typedef struct packed {
      logic              valid;
      logic [ADDR_W-1:0] addr;
   } sb_entry_t;

   // $0 is hard-wired to zero, so a write to it can never create a dependency.
   function automatic logic addr_hit(sb_entry_t e, logic [ADDR_W-1:0] r);
      return e.valid && (e.addr == r) && (r != '0);
   endfunction

endpackage

// File: rtl/hazard_scoreboard.sv
// Shift-register record of destination registers in EX, MEM and WB, with
// two parallel lookups for the ID-stage source operands.
module hazard_scoreboard
   import pipe_ctrl_pkg::*;
#(
   parameter int unsigned DEPTH     = 3,
   parameter bit          RF_BYPASS = 1'b0
) (
   input  logic              clk_i,
   input  logic              rst_n,
   input  logic              ins_valid_i,
   input  logic [ADDR_W-1:0] ins_addr_i,
   input  logic [ADDR_W-1:0] rs_i,
   input  logic [ADDR_W-1:0] rt_i,
   output logic              rs_match_o,
   output logic              rt_match_o
);

   // With a write-through RF the oldest entry is already readable at ID.
   localparam int unsigned MatchDepth = RF_BYPASS ? DEPTH - 1 : DEPTH;

   sb_entry_t sb_q [DEPTH];

   // Advance every entry one stage per cycle; entry 0 takes the issuing instruction.
   always_ff @(posedge clk_i or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned k = 0; k < DEPTH; k++) begin
            sb_q[k] <= '0;
         end
      end else begin
         sb_q[0].valid <= ins_valid_i;
         sb_q[0].addr  <= ins_addr_i;
         for (int unsigned k = 1; k < DEPTH; k++) begin
            sb_q[k] <= sb_q[k-1];
         end
      end
   end

   // Compare both source operands against every entry that can still be unwritten.
   always_comb begin
      rs_match_o = 1'b0;
      rt_match_o = 1'b0;
      for (int unsigned k = 0; k < MatchDepth; k++) begin
         if (addr_hit(sb_q[k], rs_i)) begin
            rs_match_o = 1'b1;
         end
         if (addr_hit(sb_q[k], rt_i)) begin
            rt_match_o = 1'b1;
         end
      end
   end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Interlock and flush sequencer for a 5-stage pipeline without forwarding.
// Stalls PC and IF/ID on a RAW hazard at ID, bubbles ID/EX, and flushes the
// wrong path after a taken branch resolved in EX. Keeps saturating
// stall/flush counters and a sticky deadlock flag.
module pipe_hazard_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int unsigned DEPTH     = 3,
   parameter bit          RF_BYPASS = 1'b0,
   parameter int unsigned FLUSH_LEN = 1,
   parameter int unsigned CNT_W     = 16
) (
   input  logic              clk_i,
   input  logic              rst_n,
   input  logic              id_valid_i,
   input  logic [ADDR_W-1:0] id_rs_i,
   input  logic [ADDR_W-1:0] id_rt_i,
   input  logic              id_uses_rs_i,
   input  logic              id_uses_rt_i,
   input  logic              id_reg_write_i,
   input  logic [ADDR_W-1:0] id_wr_reg_i,
   input  logic              ex_br_taken_i,
   output logic              pc_write_o,
   output logic              ifid_write_o,
   output logic              ifid_flush_o,
   output logic              idex_bubble_o,
   output logic [CNT_W-1:0]  stall_cycles_o,
   output logic [CNT_W-1:0]  stall_events_o,
   output logic [CNT_W-1:0]  flush_events_o,
   output logic              err_o
);

   localparam int unsigned FcntW = (FLUSH_LEN > 1) ? $clog2(FLUSH_LEN) : 1;
   localparam int unsigned RunW  = $clog2(DEPTH + 2);
   localparam logic [FcntW-1:0] FcntInit = FcntW'(FLUSH_LEN - 1);
   localparam logic [RunW-1:0]  RunLimit = RunW'(DEPTH);

   state_e           state_q;
   logic [FcntW-1:0] fcnt_q;
   logic [RunW-1:0]  run_q;
   logic [CNT_W-1:0] stall_cycles_q;
   logic [CNT_W-1:0] stall_events_q;
   logic [CNT_W-1:0] flush_events_q;
   logic             err_q;

   logic rs_match;
   logic rt_match;
   logic hazard;
   logic flush;
   logic stalled;
   logic sb_ins;

   hazard_scoreboard #(
      .DEPTH     (DEPTH),
      .RF_BYPASS (RF_BYPASS)
   ) u_scoreboard (
      .clk_i       (clk_i),
      .rst_n       (rst_n),
      .ins_valid_i (sb_ins),
      .ins_addr_i  (id_wr_reg_i),
      .rs_i        (id_rs_i),
      .rt_i        (id_rt_i),
      .rs_match_o  (rs_match),
      .rt_match_o  (rt_match)
   );

   // Hazard, flush and stall qualifiers for the current ID/EX contents.
   always_comb begin
      hazard  = id_valid_i & ((id_uses_rs_i & rs_match) | (id_uses_rt_i & rt_match));
      // Gated by reset so a taken-branch input cannot flush while reset is held.
      flush   = rst_n & (ex_br_taken_i | (state_q == StFlush));
      stalled = hazard & ~flush;
      // Only instructions that actually issue into EX become producers.
      sb_ins  = id_valid_i & id_reg_write_i & (id_wr_reg_i != '0) & ~hazard & ~flush;
   end

   // Pipeline-register enables; flush wins over hazard.
   always_comb begin
      pc_write_o    = flush | ~hazard;
      ifid_write_o  = flush | ~hazard;
      ifid_flush_o  = flush;
      idex_bubble_o = flush | hazard;
   end

   assign stall_cycles_o = stall_cycles_q;
   assign stall_events_o = stall_events_q;
   assign flush_events_o = flush_events_q;
   assign err_o          = err_q;

   // Sequencer state, flush length counter, performance counters and deadlock flag.
   always_ff @(posedge clk_i or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= StRun;
         fcnt_q         <= '0;
         run_q          <= '0;
         stall_cycles_q <= '0;
         stall_events_q <= '0;
         flush_events_q <= '0;
         err_q          <= 1'b0;
      end else begin
         unique case (state_q)
            StRun: begin
               if (ex_br_taken_i) begin
                  if (FLUSH_LEN > 1) begin
                     state_q <= StFlush;
                     fcnt_q  <= FcntInit;
                  end
               end else if (hazard) begin
                  state_q <= StStall;
                  if (~&stall_events_q) begin
                     stall_events_q <= stall_events_q + 1'b1;
                  end
               end
            end
            StStall: begin
               if (ex_br_taken_i) begin
                  state_q <= (FLUSH_LEN > 1) ? StFlush : StRun;
                  fcnt_q  <= FcntInit;
               end else if (!hazard) begin
                  state_q <= StRun;
               end
            end
            StFlush: begin
               // A new taken branch restarts the flush window.
               if (ex_br_taken_i) begin
                  fcnt_q <= FcntInit;
               end else if (fcnt_q == FcntW'(1)) begin
                  state_q <= hazard ? StStall : StRun;
               end else begin
                  fcnt_q <= fcnt_q - 1'b1;
               end
            end
            default: begin
               state_q <= StRun;
            end
         endcase

         if (stalled) begin
            if (~&stall_cycles_q) begin
               stall_cycles_q <= stall_cycles_q + 1'b1;
            end
            if (run_q < RunLimit) begin
               run_q <= run_q + 1'b1;
            end
            // This cycle is stall number run_q+1; more than DEPTH means nothing will drain.
            if (run_q >= RunLimit) begin
               err_q <= 1'b1;
            end
         end else begin
            run_q <= '0;
         end

         if (ex_br_taken_i && ~&flush_events_q) begin
            flush_events_q <= flush_events_q + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: two instances (no bypass / single-cycle flush,
// and RF bypass / two-cycle flush) driven with identical stimulus.
module tb_pipe_hazard_ctrl;

   localparam int NB      = 2;
   localparam int DEPTH   = 3;
   localparam int CNT_W   = 16;
   localparam int CNT_MAX = (1 << CNT_W) - 1;

   logic       clk;
   logic       rst_n;
   logic       id_valid;
   logic [4:0] id_rs;
   logic [4:0] id_rt;
   logic       uses_rs;
   logic       uses_rt;
   logic       reg_write;
   logic [4:0] wr_reg;
   logic       br;

   logic             pcw [NB];
   logic             ifw [NB];
   logic             ifl [NB];
   logic             bub [NB];
   logic             err [NB];
   logic [CNT_W-1:0] sc  [NB];
   logic [CNT_W-1:0] se  [NB];
   logic [CNT_W-1:0] fe  [NB];

   int checks;
   int errors;

   pipe_hazard_ctrl #(
      .DEPTH(DEPTH), .RF_BYPASS(1'b0), .FLUSH_LEN(1), .CNT_W(CNT_W)
   ) u_dut0 (
      .clk_i(clk), .rst_n(rst_n), .id_valid_i(id_valid), .id_rs_i(id_rs), .id_rt_i(id_rt),
      .id_uses_rs_i(uses_rs), .id_uses_rt_i(uses_rt), .id_reg_write_i(reg_write),
      .id_wr_reg_i(wr_reg), .ex_br_taken_i(br), .pc_write_o(pcw[0]), .ifid_write_o(ifw[0]),
      .ifid_flush_o(ifl[0]), .idex_bubble_o(bub[0]), .stall_cycles_o(sc[0]),
      .stall_events_o(se[0]), .flush_events_o(fe[0]), .err_o(err[0])
   );

   pipe_hazard_ctrl #(
      .DEPTH(DEPTH), .RF_BYPASS(1'b1), .FLUSH_LEN(2), .CNT_W(CNT_W)
   ) u_dut1 (
      .clk_i(clk), .rst_n(rst_n), .id_valid_i(id_valid), .id_rs_i(id_rs), .id_rt_i(id_rt),
      .id_uses_rs_i(uses_rs), .id_uses_rt_i(uses_rt), .id_reg_write_i(reg_write),
      .id_wr_reg_i(wr_reg), .ex_br_taken_i(br), .pc_write_o(pcw[1]), .ifid_write_o(ifw[1]),
      .ifid_flush_o(ifl[1]), .idex_bubble_o(bub[1]), .stall_cycles_o(sc[1]),
      .stall_events_o(se[1]), .flush_events_o(fe[1]), .err_o(err[1])
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   // A write issued at cycle c blocks readers at cycles c+1 .. c+window.
   longint last_wr   [NB][32];
   int     flush_rem [NB];
   int     m_sc      [NB];
   int     m_se      [NB];
   int     m_fe      [NB];
   int     run_len   [NB];
   bit     m_err     [NB];
   bit     in_stall  [NB];
   longint cyc;

   function automatic int win(int b);
      return (b == 0) ? DEPTH : DEPTH - 1;
   endfunction

   function automatic int flen(int b);
      return (b == 0) ? 1 : 2;
   endfunction

   function automatic bit m_hit(int b, logic [4:0] r);
      return (r != 5'd0) && ((cyc - last_wr[b][r]) <= longint'(win(b)));
   endfunction

   function automatic bit m_hazard(int b);
      return id_valid && ((uses_rs && m_hit(b, id_rs)) || (uses_rt && m_hit(b, id_rt)));
   endfunction

   function automatic bit m_flush(int b);
      return br || (flush_rem[b] > 0);
   endfunction

   task automatic m_reset();
      for (int b = 0; b < NB; b++) begin
         for (int r = 0; r < 32; r++) last_wr[b][r] = -1000;
         flush_rem[b] = 0;
         m_sc[b] = 0;
         m_se[b] = 0;
         m_fe[b] = 0;
         run_len[b] = 0;
         m_err[b] = 1'b0;
         in_stall[b] = 1'b0;
      end
      cyc = 0;
   endtask

   // Advance the model across the coming clock edge using the current inputs.
   task automatic m_commit();
      for (int b = 0; b < NB; b++) begin
         automatic bit hz = m_hazard(b);
         automatic bit fl = m_flush(b);
         automatic bit st = hz && !fl;
         if (id_valid && reg_write && wr_reg != 5'd0 && !hz && !fl) last_wr[b][wr_reg] = cyc;
         if (st && !in_stall[b] && m_se[b] < CNT_MAX) m_se[b]++;
         if (st && m_sc[b] < CNT_MAX) m_sc[b]++;
         if (br && m_fe[b] < CNT_MAX) m_fe[b]++;
         run_len[b] = st ? run_len[b] + 1 : 0;
         if (run_len[b] > DEPTH) m_err[b] = 1'b1;
         // Stalled afterwards: a plain stall, or a multi-cycle flush ending onto a hazard.
         in_stall[b] = hz && (!fl || (flush_rem[b] == 1 && !br));
         if (br) flush_rem[b] = flen(b) - 1;
         else if (flush_rem[b] > 0) flush_rem[b]--;
      end
      cyc++;
   endtask

   // ---------------- stimulus helpers ----------------
   task automatic drive(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                        input logic urs, input logic urt, input logic rw,
                        input logic [4:0] wr, input logic b);
      id_valid  = v;
      id_rs     = rs;
      id_rt     = rt;
      uses_rs   = urs;
      uses_rt   = urt;
      reg_write = rw;
      wr_reg    = wr;
      br        = b;
   endtask

   task automatic apply_reset();
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      m_reset();
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      apply_reset();
      repeat (3) @(posedge clk);
      #2;
      for (int b = 0; b < NB; b++) begin
         checks++;
         if ({pcw[b], ifw[b], ifl[b], bub[b], err[b]} !== 5'b11000) begin
            errors++;
            $display("FAIL reset_ctrl dut%0d got %b exp 11000", b,
                     {pcw[b], ifw[b], ifl[b], bub[b], err[b]});
         end
         checks++;
         if ({sc[b], se[b], fe[b]} !== '0) begin
            errors++;
            $display("FAIL reset_counters dut%0d got %0d/%0d/%0d exp 0/0/0", b, sc[b], se[b], fe[b]);
         end
      end
   endtask

   task automatic test_raw_stall();
      logic eb;
      apply_reset();
      @(posedge clk); #1 drive(1, 0, 0, 0, 0, 1, 5'd3, 0);
      #1;
      checks++;
      if (bub[0] !== 1'b0) begin
         errors++;
         $display("FAIL raw_producer bubble got %b exp 0", bub[0]);
      end
      for (int i = 1; i <= 4; i++) begin
         @(posedge clk); #1 drive(1, 5'd3, 5'd0, 1, 0, 0, 5'd0, 0);
         #1;
         for (int b = 0; b < NB; b++) begin
            eb = (i <= win(b));
            checks++;
            if ({bub[b], pcw[b], ifw[b]} !== {eb, !eb, !eb}) begin
               errors++;
               $display("FAIL raw_stall dut%0d step %0d got bub/pc/ifid %b exp %b", b, i,
                        {bub[b], pcw[b], ifw[b]}, {eb, !eb, !eb});
            end
         end
      end
      @(posedge clk); #1 drive(0, 0, 0, 0, 0, 0, 0, 0);
      #1;
      for (int b = 0; b < NB; b++) begin
         checks++;
         if (sc[b] !== CNT_W'(win(b)) || se[b] !== CNT_W'(1)) begin
            errors++;
            $display("FAIL raw_counters dut%0d got cycles %0d events %0d exp %0d 1", b, sc[b], se[b],
                     win(b));
         end
      end
   endtask

   task automatic test_zero_reg();
      apply_reset();
      @(posedge clk); #1 drive(1, 0, 0, 0, 0, 1, 5'd0, 0);
      for (int i = 0; i < 2; i++) begin
         @(posedge clk); #1 drive(1, 5'd0, 5'd0, 1, 1, 0, 5'd0, 0);
         #1;
         for (int b = 0; b < NB; b++) begin
            checks++;
            if ({bub[b], pcw[b]} !== 2'b01) begin
               errors++;
               $display("FAIL zero_reg dut%0d step %0d got bub/pc %b exp 01", b, i, {bub[b], pcw[b]});
            end
         end
      end
      @(posedge clk); #1 drive(0, 0, 0, 0, 0, 0, 0, 0);
      #1;
      checks++;
      if (sc[0] !== '0 || se[0] !== '0) begin
         errors++;
         $display("FAIL zero_reg_counters got %0d %0d exp 0 0", sc[0], se[0]);
      end
   endtask

   task automatic test_branch_flush();
      apply_reset();
      @(posedge clk); #1 drive(1, 0, 0, 0, 0, 1, 5'd3, 0);
      // Hazard on $3 coincides with a taken branch; the ID instruction also writes $5.
      @(posedge clk); #1 drive(1, 5'd3, 5'd0, 1, 0, 1, 5'd5, 1);
      #1;
      for (int b = 0; b < NB; b++) begin
         checks++;
         if ({ifl[b], bub[b], pcw[b], ifw[b]} !== 4'b1111) begin
            errors++;
            $display("FAIL branch_flush dut%0d got flush/bub/pc/ifid %b exp 1111", b,
                     {ifl[b], bub[b], pcw[b], ifw[b]});
         end
      end
      @(posedge clk); #1 drive(1, 5'd5, 5'd0, 1, 0, 0, 5'd0, 0);
      #1;
      checks++;
      if ({ifl[0], bub[0]} !== 2'b00) begin
         errors++;
         $display("FAIL branch_no_insert dut0 got flush/bub %b exp 00", {ifl[0], bub[0]});
      end
      checks++;
      if ({ifl[1], bub[1], pcw[1]} !== 3'b111) begin
         errors++;
         $display("FAIL branch_flush_len2 dut1 got flush/bub/pc %b exp 111", {ifl[1], bub[1], pcw[1]});
      end
      @(posedge clk); #1 drive(0, 0, 0, 0, 0, 0, 0, 0);
      #1;
      for (int b = 0; b < NB; b++) begin
         checks++;
         if (fe[b] !== CNT_W'(1) || sc[b] !== '0 || ifl[b] !== 1'b0) begin
            errors++;
            $display("FAIL branch_counters dut%0d got flushes %0d stalls %0d flush %b exp 1 0 0", b,
                     fe[b], sc[b], ifl[b]);
         end
      end
   endtask

   task automatic test_reset_mid_stall();
      apply_reset();
      @(posedge clk); #1 drive(1, 0, 0, 0, 0, 1, 5'd3, 0);
      @(posedge clk); #1 drive(1, 5'd3, 5'd0, 1, 0, 0, 5'd0, 0);
      @(posedge clk); #1;
      checks++;
      if (bub[0] !== 1'b1) begin
         errors++;
         $display("FAIL mid_stall_pre bubble got %b exp 1", bub[0]);
      end
      rst_n = 1'b0;
      #1;
      for (int b = 0; b < NB; b++) begin
         checks++;
         if ({pcw[b], ifw[b], ifl[b], bub[b], err[b]} !== 5'b11000 ||
             {sc[b], se[b], fe[b]} !== '0) begin
            errors++;
            $display("FAIL mid_stall_reset dut%0d got ctrl %b cnt %0d/%0d/%0d exp 11000 0/0/0", b,
                     {pcw[b], ifw[b], ifl[b], bub[b], err[b]}, sc[b], se[b], fe[b]);
         end
      end
      @(posedge clk); #1 rst_n = 1'b1;
      @(posedge clk); #1;
      for (int b = 0; b < NB; b++) begin
         checks++;
         if ({bub[b], pcw[b]} !== 2'b01) begin
            errors++;
            $display("FAIL post_reset_read dut%0d got bub/pc %b exp 01", b, {bub[b], pcw[b]});
         end
      end
   endtask

   task automatic test_random();
      logic [4:0] exp_ctrl;
      logic       hz;
      logic       fl;
      apply_reset();
      for (int n = 0; n < 3000; n++) begin
         @(posedge clk); #1;
         drive(($urandom % 4) != 0, 5'($urandom % 4), 5'($urandom % 4), 1'($urandom % 2),
               1'($urandom % 2), 1'($urandom % 2), 5'($urandom % 4), ($urandom % 10) == 0);
         #1;
         for (int b = 0; b < NB; b++) begin
            hz = m_hazard(b);
            fl = m_flush(b);
            exp_ctrl = {fl | !hz, fl | !hz, fl, fl | hz, m_err[b]};
            checks++;
            if ({pcw[b], ifw[b], ifl[b], bub[b], err[b]} !== exp_ctrl) begin
               errors++;
               $display("FAIL random_ctrl dut%0d cycle %0d got pc/ifid/flush/bub/err %b exp %b", b, n,
                        {pcw[b], ifw[b], ifl[b], bub[b], err[b]}, exp_ctrl);
            end
            checks++;
            if ({sc[b], se[b], fe[b]} !== {CNT_W'(m_sc[b]), CNT_W'(m_se[b]), CNT_W'(m_fe[b])}) begin
               errors++;
               $display("FAIL random_counters dut%0d cycle %0d got %0d/%0d/%0d exp %0d/%0d/%0d", b, n,
                        sc[b], se[b], fe[b], m_sc[b], m_se[b], m_fe[b]);
            end
         end
         m_commit();
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rst_n  = 1'b0;
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      m_reset();
      test_reset();
      test_raw_stall();
      test_zero_reg();
      test_branch_flush();
      test_reset_mid_stall();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
